// File: rtl/lcd_fifo_wr_arbiter.sv
// Write-side controller for the 20-bit LCD pixel FIFO: burst-granular round-robin
// sharing of the FIFO write port between two pixel sources.
module lcd_fifo_wr_arbiter #(
  parameter int unsigned BURST = 16,
  parameter int unsigned CW    = 8
) (
  input  logic        wrclk,
  input  logic        aclr,
  input  logic        s0_req,
  input  logic        s1_req,
  input  logic        s0_valid,
  input  logic        s1_valid,
  input  logic [19:0] s0_data,
  input  logic [19:0] s1_data,
  input  logic        s0_last,
  input  logic        s1_last,
  output logic        s0_ready,
  output logic        s1_ready,
  output logic [1:0]  grant,
  output logic [19:0] fifo_data,
  output logic        fifo_wrreq,
  input  logic        fifo_wrfull,
  input  logic        fifo_almost_full,
  output logic        busy
);

  localparam int unsigned DW = 20;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

  state_t          state, state_d;
  logic [1:0]      grant_d;
  logic            rr, rr_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d;
  logic            acc;
  logic            last_w;
  logic [DW-1:0]   data_w;

  // Ready is combinational so a full flag stops acceptance in the same cycle
  assign s0_ready = (state == ST_BURST) && grant[0] && !fifo_wrfull;
  assign s1_ready = (state == ST_BURST) && grant[1] && !fifo_wrfull;

  assign acc    = (s0_ready && s0_valid) || (s1_ready && s1_valid);
  assign last_w = grant[0] ? s0_last : s1_last;
  assign data_w = grant[0] ? s0_data : s1_data;

  // Next-state, grant, round-robin pointer and burst counter
  always_comb begin
    state_d = state;
    grant_d = grant;
    rr_d    = rr;
    cnt_d   = cnt;
    unique case (state)
      ST_IDLE: begin
        if ((s0_req || s1_req) && !fifo_almost_full) begin
          state_d = ST_BURST;
          cnt_d   = '0;
          if (s0_req && (!s1_req || !rr)) grant_d = 2'b01;
          else                           grant_d = 2'b10;
        end
      end
      ST_BURST: begin
        if (acc) begin
          if ((cnt == CW'(BURST - 1)) || last_w) begin
            state_d = ST_GAP;
            grant_d = 2'b00;
            rr_d    = grant[0];
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      rr         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      rr         <= rr_d;
      cnt        <= cnt_d;
      busy       <= busy_d;
      fifo_wrreq <= acc;
      if (acc) fifo_data <= data_w;
    end
  end

endmodule

// File: tb/tb_lcd_fifo_wr_arbiter.sv
// Directed bench for lcd_fifo_wr_arbiter: reset, bursts, contention, short burst,
// flow control and reset mid-burst, with written words collected into a queue.
module tb_lcd_fifo_wr_arbiter;

  logic        wrclk = 1'b0;
  logic        aclr = 1'b0;
  logic        s0_req = 1'b0, s1_req = 1'b0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [19:0] s0_data = '0, s1_data = '0;
  logic        s0_last = 1'b0, s1_last = 1'b0;
  logic        s0_ready, s1_ready;
  logic [1:0]  grant;
  logic [19:0] fifo_data;
  logic        fifo_wrreq;
  logic        fifo_wrfull = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int i0 = 0, i1 = 0;   // source-side word index (advances on handshake)
  int e0 = 0, e1 = 0;   // next word index expected in the FIFO per source
  logic [19:0] wq[$];

  lcd_fifo_wr_arbiter #(.BURST(16), .CW(8)) dut (
    .wrclk(wrclk), .aclr(aclr),
    .s0_req(s0_req), .s1_req(s1_req),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_data(s0_data), .s1_data(s1_data),
    .s0_last(s0_last), .s1_last(s1_last),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .grant(grant), .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq),
    .fifo_wrfull(fifo_wrfull), .fifo_almost_full(fifo_almost_full),
    .busy(busy)
  );

  always #5 wrclk = ~wrclk;

  always @(posedge wrclk) if (fifo_wrreq) wq.push_back(fifo_data);

  function automatic logic [19:0] word(input int src, input int idx);
    logic [19:0] w;
    w = 20'(idx);
    if (src != 0) w = w | 20'h80000;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic a0, a1;
    @(negedge wrclk);
    a0 = s0_ready && s0_valid;
    a1 = s1_ready && s1_valid;
    @(posedge wrclk);
    #1;
    if (a0) i0++;
    if (a1) i1++;
    s0_data = word(0, i0);
    s1_data = word(1, i1);
  endtask

  task automatic check_burst(input string tag, input int src, input int n);
    logic [19:0] w;
    for (int k = 0; k < n; k++) begin
      if (wq.size() == 0) begin
        check({tag, "_short"}, 32'(wq.size()), 32'(n - k));
        return;
      end
      w = wq.pop_front();
      check(tag, 32'(w), 32'(word(src, (src == 0) ? e0 : e1)));
      if (src == 0) e0++; else e1++;
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({grant, busy, fifo_wrreq, s0_ready, s1_ready, fifo_data});
  endfunction

  logic [1:0] g_seq[4];
  logic [1:0] g_exp[4];
  logic [1:0] prev_g;
  int nb, idle;

  initial begin
    s0_data = word(0, 0);
    s1_data = word(1, 0);
    #1 aclr = 1'b1;
    // Reset values
    for (int c = 0; c < 3; c++) begin
      tick();
      check("reset_hold", outs(), 32'h0);
    end
    aclr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("reset_idle", outs(), 32'h0);
    end

    // Single burst from source 0
    s0_req = 1'b1; s0_valid = 1'b1;
    tick();
    check("single_grant", 32'({grant, busy, s0_ready, s1_ready}), 32'b01110);
    tick();
    s0_req = 1'b0;
    check("single_first_wrreq", 32'(fifo_wrreq), 32'h1);
    check("single_first_data", 32'(fifo_data), 32'(word(0, 0)));
    for (int c = 0; c < 14; c++) tick();
    check("single_grant_held", 32'(grant), 32'b01);
    tick();
    check("single_end", 32'({grant, busy, fifo_wrreq}), 32'b0011);
    tick();
    check("single_gap_done", 32'({grant, busy, fifo_wrreq}), 32'b0000);
    check_burst("single_word", 0, 16);
    check("single_count", 32'(wq.size()), 32'h0);

    // Contention: rr now points at source 1
    s0_req = 1'b1; s1_req = 1'b1; s1_valid = 1'b1;
    g_exp[0] = 2'b10; g_exp[1] = 2'b01; g_exp[2] = 2'b10; g_exp[3] = 2'b01;
    nb = 0; idle = 0; prev_g = 2'b00;
    for (int c = 0; c < 200 && nb < 4; c++) begin
      tick();
      if (grant != 2'b00 && prev_g == 2'b00) begin
        if (nb > 0) check("cont_gap", 32'(idle), 32'd2);
        g_seq[nb] = grant;
        nb++;
        idle = 0;
      end
      if (grant == 2'b00) idle++;
      prev_g = grant;
    end
    check("cont_bursts", 32'(nb), 32'd4);
    s0_req = 1'b0; s1_req = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    for (int k = 0; k < nb; k++) begin
      check("cont_grant", 32'(g_seq[k]), 32'(g_exp[k]));
      check_burst("cont_word", (g_seq[k] == 2'b01) ? 0 : 1, 16);
    end
    check("cont_count", 32'(wq.size()), 32'h0);

    // Short burst with stall on source 1
    s1_req = 1'b1;
    tick();
    check("short_grant", 32'({grant, s0_ready, s1_ready}), 32'b1001);
    s1_req = 1'b0;
    tick();
    tick();
    s1_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("short_stall", 32'({fifo_wrreq, s1_ready, grant}), 32'b0110);
    end
    s1_valid = 1'b1;
    tick();
    tick();
    s1_last = 1'b1;
    tick();
    check("short_end", 32'({grant, busy}), 32'b001);
    s1_last = 1'b0;
    s1_valid = 1'b0;
    tick();
    tick();
    check_burst("short_word", 1, 5);
    check("short_count", 32'(wq.size()), 32'h0);

    // Almost-full holds off arbitration; rr now favours source 0
    s0_req = 1'b1; s1_req = 1'b1; fifo_almost_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("afull_nogrant", 32'({grant, busy}), 32'b000);
    end
    fifo_almost_full = 1'b0;
    tick();
    check("afull_grant_rr", 32'(grant), 32'b01);
    s0_req = 1'b0; s1_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    // Full guard for two cycles mid-burst
    fifo_wrfull = 1'b1;
    #1;
    check("full_ready_drop", 32'({s0_ready, s1_ready}), 32'b00);
    tick();
    check("full_nowrite1", 32'({fifo_wrreq, s0_ready}), 32'b00);
    tick();
    check("full_nowrite2", 32'({fifo_wrreq, s0_ready}), 32'b00);
    fifo_wrfull = 1'b0;
    #1;
    check("full_ready_back", 32'(s0_ready), 32'h1);
    for (int c = 0; c < 3; c++) tick();
    s0_valid = 1'b0;
    tick();

    // Reset mid-burst after word 7
    aclr = 1'b1;
    #1;
    check("midrst_outs", outs(), 32'h0);
    tick();
    tick();
    s0_req = 1'b1; s1_req = 1'b1;
    aclr = 1'b0;
    tick();
    check("midrst_next_grant", 32'(grant), 32'b01);
    check_burst("midrst_word", 0, 7);
    check("midrst_count", 32'(wq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
